mem_dump_reader: RTL and testbench

Memory readback engine for the RISC_SPM 256x8 RAM, the read-side counterpart of the program/data loading path.
- On a start request, reads a contiguous address range from the RAM read port.
- Streams the bytes out over a valid/ready byte interface (debug/host side).
- Sits beside the RAM; used to dump program and result regions after a run, e.g. after HALT.

---
 rtl/mem_dump_reader.sv | 118 +++++++++++
 tb/tb_mem_dump_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: streams a RAM address range out over a valid/ready byte port.
// Defining MEM_DUMP_CHECKSUM_EN appends a mod-256 sum byte after the data.
module mem_dump_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
`ifdef MEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && length == '0) begin
                    state_d = DONE;
                end else if (start) begin
                    cur_addr_d  = start_addr;
                    remaining_d = (length > MAX_LEN) ? MAX_LEN : length;
                    state_d     = FETCH;
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum_d       = '0;
`endif
                end
            end
            FETCH: begin
                mem_addr_d = cur_addr_q;
                out_data_d = mem_data;
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum_d       = sum_q + out_data_q;
                    out_data_d  = (remaining_q == LEN_W'(1)) ? sum_d : out_data_q;
                    state_d     = (remaining_q == LEN_W'(1)) ? CSUM : FETCH;
`else
                    state_d     = (remaining_q == LEN_W'(1)) ? DONE : FETCH;
`endif
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM: state_d = out_ready ? DONE : CSUM;
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // the RAM reads combinationally, so the address must be live during FETCH itself
    assign mem_rd   = state_q == FETCH;
    assign mem_addr = mem_rd ? cur_addr_q : mem_addr_q;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign out_data = out_data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    assign out_valid = state_q == SEND || state_q == CSUM;
`else
    assign out_valid = state_q == SEND;
`endif
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: directed checks of mem_dump_reader against hand-computed byte streams.
module tb_mem_dump_reader;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [7:0] start_addr = '0;
    logic [8:0] length = '0;
    logic       busy, done, mem_rd, out_valid;
    logic [7:0] mem_addr, mem_data, out_data;
    logic [7:0] ram [256];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int         got_cyc [$];
    int         n_assert = 0, n_fail = 0;
    int         cyc, done_cnt, done_cyc, rd_cnt, valid_cnt, bad, s;

    always #5 clk = ~clk;
    assign mem_data = ram[mem_addr];

    mem_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        got.delete();
        got_cyc.delete();
        exp_q.delete();
        cyc = 0;
        done_cnt = 0;
        done_cyc = -1;
        rd_cnt = 0;
        valid_cnt = 0;
    endtask

    task automatic pulse(input logic [7:0] a, input logic [8:0] l);
        start = 1'b1;
        start_addr = a;
        length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (mem_rd) rd_cnt++;
            if (out_valid) valid_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, " byte count"}, got.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) bad++;
        chk({tag, " bytes wrong"}, bad, 0);
    endtask

    task automatic chk_gaps(input string tag, input int n_data);
        bad = 0;
        for (int i = 1; i < n_data && i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != 2) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        ram[128] = 8'h06; ram[129] = 8'h01; ram[130] = 8'h02; ram[131] = 8'h00;
        ram[254] = 8'hAA; ram[255] = 8'hBB; ram[0] = 8'h00; ram[1] = 8'h52;

        #1 rst = 1'b1;
        #2;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst mem_rd", mem_rd, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        clear();
        exp_q = '{8'h06, 8'h01, 8'h02, 8'h00};
        if (CSUM) exp_q.push_back(8'h09);
        pulse(8'd128, 9'd4);
        watch(20);
        chk_stream("basic");
        chk_gaps("basic spacing", 4);
        chk("basic done count", done_cnt, 1);
        chk("basic mem_rd count", rd_cnt, 4);
        chk("basic busy after", busy, 0);
        chk("basic mem_addr hold", mem_addr, 8'd131);

        clear();
        exp_q = '{8'hAA, 8'hBB, 8'h00, 8'h52};
        if (CSUM) exp_q.push_back(8'hB7);
        pulse(8'd254, 9'd4);
        watch(20);
        chk_stream("wrap");
        chk("wrap done count", done_cnt, 1);
        chk("wrap mem_addr hold", mem_addr, 8'd1);

        clear();
        exp_q = '{8'h06, 8'h01, 8'h02, 8'h00};
        if (CSUM) exp_q.push_back(8'h09);
        pulse(8'd128, 9'd4);
        watch(2);
        out_ready = 1'b0;
        watch(1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(out_valid === 1'b1 && out_data === 8'h01 && mem_rd === 1'b0 && busy === 1'b1)) bad++;
            watch(1);
        end
        chk("stall hold", bad, 0);
        out_ready = 1'b1;
        watch(20);
        chk_stream("stall");
        chk("stall done count", done_cnt, 1);
        chk("stall mem_rd count", rd_cnt, 4);

        clear();
        pulse(8'h10, 9'd0);
        watch(6);
        chk("len0 out_valid count", valid_cnt, 0);
        chk("len0 mem_rd count", rd_cnt, 0);
        chk("len0 done count", done_cnt, 1);
        chk("len0 done cycle", done_cyc, 0);

        clear();
        pulse(8'd128, 9'd4);
        watch(5);
        chk("pre-reset bytes", got.size(), 2);
        chk("pre-reset out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst busy", busy, 0);
        chk("async rst mem_rd", mem_rd, 0);
        chk("async rst out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        clear();
        watch(3);
        chk("post-reset idle valid", valid_cnt, 0);
        clear();
        exp_q = '{8'h02, 8'h00};
        if (CSUM) exp_q.push_back(8'h02);
        pulse(8'd130, 9'd2);
        watch(12);
        chk_stream("after reset");
        chk("after reset done count", done_cnt, 1);

        clear();
        s = 0;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(ram[i]);
            s += ram[i];
        end
        if (CSUM) exp_q.push_back(8'(s));
        pulse(8'd0, 9'd256);
        watch(40);
        start = 1'b1;
        start_addr = 8'h05;
        length = 9'd3;
        watch(1);
        start = 1'b0;
        watch(600);
        chk_stream("full");
        chk_gaps("full spacing", 256);
        chk("full done count", done_cnt, 1);
        chk("full mem_rd count", rd_cnt, 256);
        chk("full mem_addr hold", mem_addr, 8'd255);

        clear();
        for (int i = 0; i < 256; i++) exp_q.push_back(ram[(i + 16) % 256]);
        if (CSUM) exp_q.push_back(8'(s));
        pulse(8'd16, 9'd300);
        watch(600);
        chk_stream("truncate");
        chk("truncate done count", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
